// File: rtl/mem_stage_pkg.sv
// +----------------------------------------------------------------------+
// | mem_stage_pkg                                                        |
// | Shared types and defaults for the MEM pipeline stage.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Control fields handed to MEM/WB
  typedef struct packed {
    logic reg_write;
    logic memto_reg;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, memto_reg: 1'b0};

  // Word accesses only: the two low address bits must be zero
  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// +----------------------------------------------------------------------+
// | mem_stage_if                                                         |
// | Data-memory req/ack bus between the MEM stage and data memory.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_stage_wait_counter.sv
// +----------------------------------------------------------------------+
// | mem_wait_counter                                                     |
// | Counts BUSY cycles spent waiting for a memory acknowledge.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_wait_counter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              i_clear,
  input  wire              i_enable,
  output logic [CNT_W-1:0] o_count,
  output logic             o_terminal
);

  logic [CNT_W-1:0] r_count;

  // Clear has priority so a fresh access always starts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_enable) r_count <= r_count + 1'b1;
  end

  assign o_count    = r_count;
  assign o_terminal = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// +----------------------------------------------------------------------+
// | mem_stage                                                            |
// | MEM pipeline stage: loads/stores over a variable-latency req/ack     |
// | bus, pipeline stall, misalignment and bus-timeout detection.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  wire               clk,
  input  wire               rst,
  input  wire               in_valid,
  input  wire               MemRead,
  input  wire               MemWrite,
  input  wire               RegWrite,
  input  wire               MemtoReg,
  input  wire  [DATA_W-1:0] Result,
  input  wire  [DATA_W-1:0] WriteData,
  input  wire  [REG_W-1:0]  MuxIn,
  output logic              stall,
  output logic              RegWriteOut,
  output logic              MemtoRegOut,
  output logic [DATA_W-1:0] ResultOut,
  output logic [DATA_W-1:0] MemReadDataOut,
  output logic [REG_W-1:0]  MuxOut,
  output logic              misalign_err,
  output logic              bus_err,
  mem_stage_if.master       dmem
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]        r_state;
  wb_ctrl_t          r_ctrl;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_rdata;
  logic [REG_W-1:0]  r_mux;
  logic              r_bus_err;

  logic              w_mem_op;
  logic              w_aligned;
  logic              w_start;
  logic              w_cnt_clear;
  logic              w_cnt_en;
  logic              w_terminal;
  logic [CNT_W-1:0]  w_count;

  // Both MemRead and MemWrite high is a store: dmem_we follows MemWrite
  assign w_mem_op    = in_valid & (MemRead | MemWrite);
  assign w_aligned   = is_aligned(Result[1:0]);
  assign w_start     = (r_state == S_IDLE) & w_mem_op & w_aligned;
  assign w_cnt_clear = (r_state != S_BUSY);
  // Hold the count at its terminal value; the timeout path leaves BUSY there
  assign w_cnt_en    = (r_state == S_BUSY) & ~dmem.dmem_ack
                     & (w_count != CNT_W'(TIMEOUT - 1));

  mem_wait_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_cnt_clear),
    .i_enable   (w_cnt_en),
    .o_count    (w_count),
    .o_terminal (w_terminal)
  );

  // MEM/WB outputs, stall and error pulses; all forced quiet during reset
  always_comb begin
    stall          = 1'b0;
    RegWriteOut    = WB_BUBBLE.reg_write;
    MemtoRegOut    = WB_BUBBLE.memto_reg;
    ResultOut      = '0;
    MemReadDataOut = '0;
    MuxOut         = '0;
    misalign_err   = 1'b0;
    bus_err        = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (!w_mem_op) begin
            RegWriteOut = in_valid & RegWrite;
            MemtoRegOut = MemtoReg;
            ResultOut   = Result;
            MuxOut      = MuxIn;
          end else if (!w_aligned) begin
            misalign_err = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
        S_BUSY: stall = 1'b1;
        S_DONE: begin
          RegWriteOut    = r_ctrl.reg_write;
          MemtoRegOut    = r_ctrl.memto_reg;
          ResultOut      = r_result;
          MemReadDataOut = r_rdata;
          MuxOut         = r_mux;
          bus_err        = r_bus_err;
        end
        default: ;
      endcase
    end
  end

  // Access sequencer: launch, wait for ack or timeout, present for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_ctrl          <= WB_BUBBLE;
      r_result        <= '0;
      r_rdata         <= '0;
      r_mux           <= '0;
      r_bus_err       <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_ctrl.reg_write <= RegWrite;
            r_ctrl.memto_reg <= MemtoReg;
            r_result         <= Result;
            r_mux            <= MuxIn;
            dmem.dmem_addr   <= Result;
            dmem.dmem_wdata  <= WriteData;
            dmem.dmem_we     <= MemWrite;
            dmem.dmem_req    <= 1'b1;
            r_state          <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dmem.dmem_ack) begin
            r_rdata       <= dmem.dmem_we ? '0 : dmem.dmem_rdata;
            dmem.dmem_req <= 1'b0;
            r_state       <= S_DONE;
          end else if (w_terminal) begin
            r_rdata       <= '0;
            r_bus_err     <= 1'b1;
            dmem.dmem_req <= 1'b0;
            r_state       <= S_DONE;
          end
        end
        S_DONE: begin
          r_bus_err <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- The MEM pipeline stage sits between the EX/MEM register and the MEM/WB register.
- It performs loads and stores against a variable-latency data memory using a req/ack handshake.
- It stalls the front of the pipeline while an access is outstanding and hands MEM/WB a bubble on every stall cycle.
- It flags misaligned addresses and bus timeouts.

Parameters:
- DATA_W, 32, data and address width.
- REG_W, 5, destination register index width.
- TIMEOUT, 16, maximum BUSY cycles without dmem_ack before a bus error (must be ≥2).

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- in_valid  in  1  EX/MEM holds a valid instruction.
- MemRead  in  1  instruction is a load.
- MemWrite  in  1  instruction is a store.
- RegWrite  in  1  instruction writes the register file.
- MemtoReg  in  1  writeback selects memory data.
- Result  in  DATA_W  ALU result; this is the address for loads and stores.
- WriteData  in  DATA_W  store data.
- MuxIn  in  REG_W  destination register index.
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- RegWriteOut  out  1  to MEM/WB.
- MemtoRegOut  out  1  to MEM/WB.
- ResultOut  out  DATA_W  to MEM/WB.
- MemReadDataOut  out  DATA_W  to MEM/WB.
- MuxOut  out  REG_W  to MEM/WB.
- dmem_req  out  1  memory request; registered.
- dmem_we  out  1  write enable; meaningful only while dmem_req=1.
- dmem_addr  out  DATA_W  word address; registered.
- dmem_wdata  out  DATA_W  store data; registered.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  DATA_W  load data; valid while dmem_ack=1.
- misalign_err  out  1  one-cycle pulse.
- bus_err  out  1  one-cycle pulse.

Behaviour:
- States: IDLE, BUSY, DONE. Reset (async) forces IDLE.
- Reset values: dmem_req=0, counter=0, captured registers=0. All outputs to MEM/WB are 0, stall=0, and both error flags are 0 while rst=1.
- Assertion of rst mid-access drops dmem_req immediately. A later dmem_ack is ignored.
- "mem op" means in_valid & (MemRead | MemWrite). MemRead and MemWrite both high is treated as a store.
- IDLE, no mem op:
  - Inputs pass combinationally to the MEM/WB outputs. MemReadDataOut=0. stall=0. Zero latency.
  - When in_valid=0, RegWriteOut=0.
- IDLE, mem op with Result[1:0]≠0:
  - misalign_err=1 this cycle. Outputs are a bubble (RegWriteOut=0, other outputs 0). stall=0.
  - No memory access. Remain in IDLE.
- IDLE, aligned mem op:
  - stall=1 combinationally. Outputs are a bubble.
  - At the edge: capture RegWrite, MemtoReg, Result, MuxIn. Load dmem_addr=Result, dmem_wdata=WriteData, dmem_we=MemWrite. Set dmem_req=1, counter=0. Go to BUSY.
- BUSY:
  - stall=1. Outputs are a bubble. dmem_req is held, and dmem_addr, dmem_wdata, dmem_we are stable.
  - dmem_ack=1: capture rdata (0 for a store), clear dmem_req, go to DONE.
  - No ack and counter=TIMEOUT-1: capture rdata=0, clear dmem_req, set the bus-error flag, go to DONE.
  - Otherwise counter increments.
- DONE (one cycle):
  - stall=0. Outputs present the captured op with MemReadDataOut equal to the captured rdata.
  - bus_err=1 if the bus-error flag is set.
  - The inputs in this cycle are the same held instruction and are ignored.
  - At the edge: go to IDLE and clear the flag.
- dmem_ack outside BUSY is ignored.
- Timing:
  - Load with ack in the first BUSY cycle: 2 stall cycles, result to MEM/WB in the 3rd cycle.
  - Ack in the k-th BUSY cycle: k+1 stall cycles.
  - Timeout: TIMEOUT+1 stall cycles.

Decomposition:
- Shared package:
  - mem_state_t enum {IDLE, BUSY, DONE}.
  - DATA_W / REG_W defaults.
  - A bubble constant for the MEM/WB control fields.
- One natural sub-module: mem_wait_counter. It takes clear and enable, and outputs count and terminal (count == TIMEOUT-1).

Test Plan:
- Reset, then ALU op (in_valid=1, RegWrite=1, Result=0x0000_0010, MuxIn=5, no mem) -> same cycle RegWriteOut=1, ResultOut=0x10, MuxOut=5, stall=0, dmem_req=0.
- Load at Result=0x100, ack after 3 BUSY cycles with rdata=0xDEAD_BEEF -> stall high for 4 cycles, dmem_addr=0x100 and dmem_we=0 held throughout. DONE cycle shows MemReadDataOut=0xDEADBEEF, MemtoRegOut=1, stall=0.
- Store at 0x204 with WriteData=0x1234_5678, ack in the first BUSY cycle -> dmem_we=1, dmem_wdata=0x12345678, 2 stall cycles, DONE shows RegWriteOut=0.
- Load at 0x102 -> misalign_err pulse of 1 cycle, RegWriteOut=0, stall=0, dmem_req never asserted.
- Load at 0x300, no ack, TIMEOUT=16 -> dmem_req high for exactly 16 cycles, then DONE with bus_err=1 and MemReadDataOut=0. A stray ack afterwards is ignored.
- Assert rst in the 2nd BUSY cycle -> dmem_req=0 and stall=0 immediately. After release, an ack pulse produces no output, and the next ALU op passes through normally.
